ms_out_demux: RTL
=================

Name: ms_out_demux

Overview:
- Receiving end of the tagged multi-stream write interface used on the accelerator output port.
- Accepts `{tag, data}` writes from the accelerator and buffers each flow in its own FIFO.
- Applies per-flow backpressure through `full[FLUX-1:0]`.
- Presents each flow as a FWFT valid/ready stream, counts frame completion against a programmed length, and measures per-flow cycle counts for throughput analysis.

Parameters:
- DATA_W, 8, payload width (pel).
- FLUX, 2, number of flows; FLUX >= 2.
- TAG_W, $clog2(FLUX), width of the flow tag; the tag is the MSBs of `din`.
- DEPTH, 16, per-flow FIFO depth; power of two.
- LEN_W, 13, frame length counter width (max 71*71 = 5041).
- CYC_W, 32, cycle counter width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous active-low reset.
- din  in  TAG_W+DATA_W  tagged write data: `{tag, pel}`.
- write  in  1  write strobe.
- full  out  FLUX  per-flow full; the writer must not write flow f while `full[f]`.
- cfg_din  in  TAG_W+LEN_W  `{tag, len}` arm command.
- cfg_write  in  1  arm strobe.
- dout  out  FLUX*DATA_W  per-flow head data; flow f is `dout[f*DATA_W +: DATA_W]`.
- valid  out  FLUX  per-flow head valid.
- ready  in  FLUX  per-flow consumer ready.
- flow_done  out  FLUX  one-cycle pulse when an armed frame is fully popped.
- flow_cycles  out  FLUX*CYC_W  cycles from arm to last pop, held until the next arm.
- err  out  3  sticky flags: [0] write to a full flow, [1] tag >= FLUX, [2] bad arm.

Behaviour:
- **Reset** (rst=0, async): FIFOs empty, full=0, valid=0, dout=0, flow_done=0, flow_cycles=0, err=0, all flows IDLE.
- **Write acceptance**: write accepted for flow t = `din[TAG_W+DATA_W-1 -: TAG_W]` iff write=1, t < FLUX and !full[t].
  - Rejected writes leave the FIFO unchanged.
  - t >= FLUX sets err[1]; write while full[t] sets err[0].
- **full[t]**: registered; equals occupancy==DEPTH. Pop on a full FIFO deasserts full on the next cycle. A write in the same cycle as full=1 is still rejected (no pass-through).
- **Read side**: FWFT. valid[f] = occupancy != 0; pop when valid[f] & ready[f].
  - Write in cycle n gives valid the cycle after the write (write-to-valid latency 1).
  - Simultaneous push and pop keeps occupancy constant; pointers wrap modulo DEPTH.
- **Flows are independent**: one flow stalled (ready=0) never blocks another flow's writes or pops.
- **Per-flow FSM**, with a pop counter and a cycle counter per flow:
  - IDLE -> ARMED on an accepted cfg_write for tag f with len != 0. Load the target with len, clear the pop counter and cycle counter.
  - ARMED: cycle counter increments every cycle and each pop increments the pop counter. When a pop makes the pop count equal len, go to DONE.
  - DONE: flow_done[f]=1 for exactly one cycle; flow_cycles[f] = cycle count including the final pop cycle; return to IDLE next cycle.
- **Arm errors**: cfg_write with len=0, tag >= FLUX, or flow not IDLE is ignored and sets err[2].
- **Pops in IDLE**: allowed, and not counted.
- **Same-cycle events**: a cfg_write arm and a pop for the same flow in the same cycle does not count that pop.
- **Counter saturation**: cycle counter saturates at all-ones.
- **Sticky errors**: err bits clear only on reset.
- **Reset mid-frame**: everything returns to reset values immediately; buffered data is discarded.

Decomposition:
- Package `ms_demux_pkg` holds:
  - the flow state enum {IDLE, ARMED, DONE};
  - the err bit index constants ERR_FULL=0, ERR_TAG=1, ERR_CFG=2;
  - a tag-width helper function.
- One natural sub-module, `ms_sync_fifo`: single-clock FWFT FIFO (DATA_W, DEPTH) with registered full and occupancy output.
  - Instantiated FLUX times in a generate loop.
  - FSMs and counters stay in the top.

Test Plan:
- **Interleaved writes**: FLUX=2; write alternately {0,0x10},{1,0x20},{0,0x11},{1,0x21}, ready=11 -> flow0 pops 0x10,0x11; flow1 pops 0x20,0x21; each valid one cycle after its write; err=0.
- **Backpressure**: ready[0]=0, write 16 words to flow0 -> full[0]=1 after the 16th. A 17th write sets err[0] and the data is dropped. One pop -> full[0]=0 the next cycle; flow1 is unaffected throughout.
- **Frame completion**: arm flow1 len=64, push 64 words with ready=1 -> flow_done[1] pulses once, in the cycle after the 64th pop. flow_cycles[1] equals the measured arm-to-last-pop cycles; the flow returns to IDLE.
- **Bad arm and tag**: re-arm flow0 while ARMED -> err[2]. Arm with len=0 -> err[2]. With FLUX=3 (TAG_W=2), write tag=3 -> err[1], and no FIFO changes.
- **Simultaneous push/pop at full**: FIFO at 16 entries, ready=1 plus write same cycle -> write rejected (err[0]), occupancy 15.
- **Reset mid-frame**: assert rst low during an ARMED frame with 8 words buffered -> valid=0, full=0, flow_cycles=0, err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ms_demux_pkg.sv
// Shared types and constants for the multi-stream output demultiplexer.
package ms_demux_pkg;

    // Per-flow frame tracking state.
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } flow_state_t;

    // Bit positions inside the sticky error vector.
    localparam int ERR_FULL = 0;
    localparam int ERR_TAG  = 1;
    localparam int ERR_CFG  = 2;

    // Tag width for n flows; never narrower than one bit.
    function automatic int tag_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full flag and
// occupancy output. Head data is forced to zero while the FIFO is empty.
module ms_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              full_reg;
    logic              push_ok;
    logic              pop_ok;

    // A push while full would overwrite the head slot, so it is dropped here too.
    assign push_ok = push & ~full_reg;
    assign pop_ok  = pop & (count_reg != '0);

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy and full flag; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
        end
    end

    assign dout      = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign full      = full_reg;
    assign occupancy = count_reg;

endmodule

// File: rtl/ms_out_demux.sv
// Receiving end of the tagged multi-stream write port: routes {tag, pel}
// writes into per-flow FIFOs, exposes each flow as a valid/ready stream and
// tracks armed frames with pop and cycle counters per flow.
module ms_out_demux
    import ms_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FLUX   = 2,
    parameter int TAG_W  = tag_width(FLUX),
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 13,
    parameter int CYC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAG_W+DATA_W-1:0] din,
    input  logic                    write,
    output logic [FLUX-1:0]         full,
    input  logic [TAG_W+LEN_W-1:0]  cfg_din,
    input  logic                    cfg_write,
    output logic [FLUX*DATA_W-1:0]  dout,
    output logic [FLUX-1:0]         valid,
    input  logic [FLUX-1:0]         ready,
    output logic [FLUX-1:0]         flow_done,
    output logic [FLUX*CYC_W-1:0]   flow_cycles,
    output logic [2:0]              err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [TAG_W:0] FLUX_L = (TAG_W + 1)'(FLUX);

    logic [TAG_W-1:0] w_tag;
    logic [DATA_W-1:0] w_pel;
    logic [TAG_W-1:0] c_tag;
    logic [LEN_W-1:0] c_len;
    logic             w_tag_ok;

    logic [FLUX-1:0] w_hit;
    logic [FLUX-1:0] push;
    logic [FLUX-1:0] pop;
    logic [FLUX-1:0] arm_ok;
    logic [FLUX-1:0] fifo_full;

    logic [2:0] err_reg;
    logic [2:0] err_set;

    assign w_tag    = din[TAG_W+DATA_W-1 -: TAG_W];
    assign w_pel    = din[DATA_W-1:0];
    assign c_tag    = cfg_din[TAG_W+LEN_W-1 -: TAG_W];
    assign c_len    = cfg_din[LEN_W-1:0];
    assign w_tag_ok = ({1'b0, w_tag} < FLUX_L);

    genvar gi;
    generate
        for (gi = 0; gi < FLUX; gi++) begin : g_flow
            logic [CNT_W-1:0] occ;
            flow_state_t      state_reg;
            flow_state_t      state_next;
            logic [LEN_W-1:0] len_reg;
            logic [LEN_W-1:0] pop_cnt_reg;
            logic [CYC_W-1:0] cyc_cnt_reg;
            logic [CYC_W-1:0] cycles_reg;
            logic             last_pop;

            assign w_hit[gi]  = write & (w_tag == TAG_W'(gi));
            assign push[gi]   = w_hit[gi] & ~fifo_full[gi];
            assign valid[gi]  = (occ != '0);
            assign pop[gi]    = valid[gi] & ready[gi];
            assign arm_ok[gi] = cfg_write & (c_tag == TAG_W'(gi)) &
                                (c_len != '0) & (state_reg == IDLE);
            assign last_pop   = pop[gi] & ((pop_cnt_reg + LEN_W'(1)) == len_reg);

            ms_sync_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push[gi]),
                .din       (w_pel),
                .pop       (pop[gi]),
                .dout      (dout[gi*DATA_W +: DATA_W]),
                .full      (fifo_full[gi]),
                .occupancy (occ)
            );

            // Frame FSM next state: arm from IDLE, finish on the len-th pop, DONE lasts one cycle.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    IDLE:    if (arm_ok[gi]) state_next = ARMED;
                    ARMED:   if (last_pop)   state_next = DONE;
                    DONE:    state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end

            // Frame state and counters; pops outside ARMED (including the arm cycle) are not counted.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg   <= IDLE;
                    len_reg     <= '0;
                    pop_cnt_reg <= '0;
                    cyc_cnt_reg <= '0;
                    cycles_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    case (state_reg)
                        IDLE: begin
                            if (arm_ok[gi]) begin
                                len_reg     <= c_len;
                                pop_cnt_reg <= '0;
                                cyc_cnt_reg <= '0;
                                cycles_reg  <= '0;
                            end
                        end
                        ARMED: begin
                            if (cyc_cnt_reg != {CYC_W{1'b1}}) begin
                                cyc_cnt_reg <= cyc_cnt_reg + CYC_W'(1);
                            end
                            if (pop[gi]) begin
                                pop_cnt_reg <= pop_cnt_reg + LEN_W'(1);
                            end
                            // Reported count includes the cycle of the final pop.
                            if (last_pop) begin
                                cycles_reg <= (cyc_cnt_reg == {CYC_W{1'b1}}) ?
                                              cyc_cnt_reg : cyc_cnt_reg + CYC_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign flow_done[gi]                     = (state_reg == DONE);
            assign flow_cycles[gi*CYC_W +: CYC_W]    = cycles_reg;
        end
    endgenerate

    // Error events raised this cycle.
    always_comb begin
        err_set           = '0;
        err_set[ERR_FULL] = |(w_hit & fifo_full);
        err_set[ERR_TAG]  = write & ~w_tag_ok;
        err_set[ERR_CFG]  = cfg_write & ~(|arm_ok);
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= '0;
        end else begin
            err_reg <= err_reg | err_set;
        end
    end

    assign full = fifo_full;
    assign err  = err_reg;

endmodule
